// File: rtl/exe_cmd_queue.sv
// exe_cmd_queue: command queue in front of an execution unit.
// Accepts {oper, argA, argB} commands from a producer and issues them in push
// order, one per cycle, through registered outputs. Issue can be paused with
// i_hold; a command pushed into an empty queue issues on the following edge.
// Optional build macro EXE_CMD_QUEUE_STATS_EN adds saturating 16-bit counters
// for issued commands (o_cnt_issued) and refused pushes (o_cnt_drop).
//
// state   | meaning
// IDLE    | queue empty, nothing to issue
// ISSUE   | queue non-empty and not held, pop one entry per cycle
// HOLD    | i_hold high, issue paused, entries retained
module exe_cmd_queue #(
  parameter int m     = 4,
  parameter int n     = 2,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic                       i_clk,
  input  logic                       i_rsn,
  input  logic                       i_valid,
  input  logic [n-1:0]               i_oper,
  input  logic signed [m-1:0]        i_argA,
  input  logic signed [m-1:0]        i_argB,
  output logic                       o_ready,
  input  logic                       i_hold,
  output logic [n-1:0]               o_oper,
  output logic [m-1:0]               o_argA,
  output logic [m-1:0]               o_argB,
  output logic                       o_issue,
  output logic [$clog2(DEPTH):0]     o_count
`ifdef EXE_CMD_QUEUE_STATS_EN
  ,
  output logic [15:0]                o_cnt_issued,
  output logic [15:0]                o_cnt_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = n + 2 * m;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nxt;
  logic            full;
  logic            push;
  logic            pop;

  assign full    = (o_count == FULL_CNT);
  assign o_ready = ~full;
  assign push    = i_valid & ~full;

  // Occupancy after this edge, used by both the counter and the FSM.
  always_comb begin
    count_nxt = o_count;
    case ({push, pop})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: hold wins, otherwise follow the post-edge occupancy.
  always_comb begin
    state_nxt = state;
    if (i_hold)                state_nxt = S_HOLD;
    else if (count_nxt != '0)  state_nxt = S_ISSUE;
    else                       state_nxt = S_IDLE;
  end

  // FSM output: pop only while issuing; a rising i_hold blocks it combinationally.
  always_comb begin
    pop = 1'b0;
    if (state == S_ISSUE && !i_hold && o_count != '0) pop = 1'b1;
  end

  // Storage write; contents are never read before being written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_oper, i_argA, i_argB};
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      o_count <= count_nxt;
    end
  end

  // Registered issue port: head loaded and strobe raised on the pop edge.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      o_issue <= 1'b0;
      o_oper  <= '0;
      o_argA  <= '0;
      o_argB  <= '0;
    end else begin
      o_issue <= pop;
      if (pop) {o_oper, o_argA, o_argB} <= mem[rd_ptr];
    end
  end

`ifdef EXE_CMD_QUEUE_STATS_EN
  // Saturating statistics; issued counts on the pop edge so it tracks o_issue.
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      o_cnt_issued <= '0;
      o_cnt_drop   <= '0;
    end else begin
      if (pop && o_cnt_issued != 16'hFFFF)                o_cnt_issued <= o_cnt_issued + 16'd1;
      if (i_valid && full && o_cnt_drop != 16'hFFFF)      o_cnt_drop   <= o_cnt_drop + 16'd1;
    end
  end
`endif

endmodule

// File: doc/exe_cmd_queue.md
EXE_CMD_QUEUE -- requirements
Module: exe_cmd_queue

Interface
REQ-001 Parameter m, default 4, SHALL set operand width in bits.
REQ-002 Parameter n, default 2, SHALL set opcode width in bits.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, SHALL set queue entries.
REQ-004 i_clk  in  1  SHALL be the sole clock; all state on rising edge.
REQ-005 i_rsn  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_valid  in  1  SHALL mark a command offered by the producer.
REQ-007 i_oper / i_argA / i_argB  in  n / m signed / m signed  SHALL carry the offered command.
REQ-008 o_ready  out  1  SHALL signal space for a command; equals !full.
REQ-009 i_hold  in  1  SHALL pause issue toward the execution unit while high.
REQ-010 o_oper / o_argA / o_argB  out  n / m / m  SHALL be registered command fields driven to the execution unit.
REQ-011 o_issue  out  1  SHALL be a registered strobe, high for one cycle per command placed on o_oper/o_argA/o_argB.
REQ-012 o_count  out  log2(DEPTH)+1  SHALL report current occupancy.

Function
REQ-013 Push SHALL occur on a rising edge with i_valid && o_ready; command written at write pointer, pointer wraps DEPTH-1 -> 0.
REQ-014 i_valid while full SHALL be ignored; queue contents, pointers and o_count unchanged.
REQ-015 FSM states SHALL be IDLE (empty), ISSUE (non-empty, not held), HOLD (i_hold high).
REQ-016 IDLE -> ISSUE when o_count becomes non-zero and i_hold low; ISSUE -> IDLE when last entry popped and no push that cycle; any state -> HOLD when i_hold high; HOLD -> ISSUE/IDLE on i_hold low per occupancy.
REQ-017 In ISSUE, one entry SHALL pop per cycle: head loaded into o_oper/o_argA/o_argB and o_issue set to 1 on the same edge.
REQ-018 In IDLE and HOLD, o_issue SHALL be 0 and o_oper/o_argA/o_argB SHALL hold their last values.
REQ-019 Latency: command pushed at edge k into an empty, un-held queue SHALL appear with o_issue=1 after edge k+1; no same-edge bypass.
REQ-020 Simultaneous push and pop SHALL leave o_count unchanged; push when full is refused even if a pop occurs that edge.
REQ-021 Commands SHALL issue in strict push order; operand bits pass unmodified (no sign change, no truncation).
REQ-022 i_hold rising SHALL block the pop on the same edge; the head entry is retained.

Reset
REQ-023 i_rsn low SHALL immediately clear pointers, o_count=0, o_issue=0, o_oper/o_argA/o_argB=0, FSM=IDLE, o_ready=1.
REQ-024 Reset mid-operation SHALL discard all queued commands; first push after i_rsn rises starts from entry 0.
REQ-025 Queue storage SHALL need no reset; contents unreadable until written.

Configuration
REQ-026 Macro EXE_CMD_QUEUE_STATS_EN SHALL, when defined, add outputs o_cnt_issued (16 bits, +1 per o_issue) and o_cnt_drop (16 bits, +1 per i_valid refused while full), both saturating at 16'hFFFF and cleared by reset.
REQ-027 Without EXE_CMD_QUEUE_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-028 Reset: i_rsn=0 mid-stream -> o_issue=0, o_count=0, o_ready=1, outputs 0 without a clock edge.
REQ-029 Single push oper=2'b11, argA=4'b1111, argB=4'b0000 into empty queue -> one cycle later o_issue=1 with those exact values, then o_issue=0, o_count=0.
REQ-030 Push 5 commands back-to-back with i_hold=1, DEPTH=4 -> o_ready=0 after 4th, 5th ignored, o_count=4 (o_cnt_drop=1 with STATS).
REQ-031 Release i_hold with 4 queued -> 4 consecutive o_issue pulses in push order, then IDLE, o_ready=1.
REQ-032 Continuous push every cycle with i_hold=0 -> o_count stays 1 in steady state, one issue per cycle, pointers wrap past 3 correctly.
REQ-033 Assert i_hold for 2 cycles mid-drain -> no o_issue during hold, head entry issued first on release, none lost or duplicated.
